axi_sram_responder: RTL and testbench
=====================================

# axi_sram_responder

AXI3 slave that accepts read and write transactions on a 32-bit AXI port and serves them from a single-port synchronous SRAM with 1-cycle read latency. It is the responder counterpart of the core's SRAM-to-AXI master bridge. It lets on-chip RAM (boot RAM, scratchpad) sit directly on the AXI interconnect. It handles single beats and FIXED/INCR bursts of up to 16 beats, one transaction at a time.

## Interface
- RAM_AW, default 16: SRAM word-address width; `ram_addr = addr[RAM_AW+1:2]`, upper address bits are dropped.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- arid[3:0] araddr[31:0] arlen[3:0] arsize[2:0] arburst[1:0] arvalid  in  AR request fields.
- arready  out  1  AR accept.
- rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid  out  R beat fields.
- rready  in  1  R accept.
- awid[3:0] awaddr[31:0] awlen[3:0] awsize[2:0] awburst[1:0] awvalid  in  AW request fields.
- awready  out  1  AW accept.
- wid[3:0] wdata[31:0] wstrb[3:0] wlast wvalid  in  W beat fields; wid is ignored.
- wready  out  1  W accept.
- bid[3:0] bresp[1:0] bvalid  out  B response fields.
- bready  in  1  B accept.
- arlock/awlock[1:0] arcache/awcache[3:0] arprot/awprot[2:0]  in  ignored.
- ram_en  out  1  SRAM access strobe.
- ram_wen  out  4  per-byte write enable; 0 means read.
- ram_addr  out  RAM_AW  SRAM word address.
- ram_wdata  out  32  SRAM write data.
- ram_rdata  in  32  SRAM read data, valid in the cycle after a read strobe.

## Operation
- FSM states: IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP.
- IDLE:
  - arready = arvalid && !grant_w; awready = awvalid && (grant_w || !arvalid).
  - grant_w = awvalid && (!arvalid || !last_w). last_w resets to 0 and is set/cleared on each AW/AR accept. Under simultaneous requests, the first one after reset goes to write, and then reads and writes alternate.
  - On accept, latch id, addr, len, size, burst, and set beats = len.
  - AR accept goes to RD_REQ; AW accept goes to WR_DATA.
- RD_REQ: ram_en=1, ram_wen=0, ram_addr from the current address. Go to RD_CAP.
- RD_CAP: register ram_rdata into the rdata register. Go to RD_RESP.
- RD_RESP:
  - rvalid=1, rid=latched id, rresp=00, rlast=(beats==0). rdata stays stable until handshake.
  - On rready: if beats==0 go to IDLE; otherwise decrement beats, advance the address, and go to RD_REQ.
- WR_DATA:
  - wready=1. On wvalid, in the same cycle: ram_en=1, ram_wen=wstrb, ram_addr from the current address, ram_wdata=wdata.
  - Then if beats==0 go to WR_RESP; otherwise decrement beats, advance the address, and stay.
  - wlast is ignored; the beat count alone ends the burst.
- WR_RESP: bvalid=1, bid=latched id, bresp=00. On bready go to IDLE.
- Address advance:
  - FIXED (00): address unchanged.
  - INCR (01) and any other burst code: addr += 1<<size, 32-bit wrap.
  - Narrow reads return the full containing word; narrow writes rely on wstrb.
- Responses are always OKAY; there are no error responses.
- ram_en and ram_wen are 0 in every cycle not listed above.

## Timing
- Reset (rst low): state goes to IDLE, last_w=0, beats=0, and all latched fields and the rdata register clear to 0.
  - While rst is low, every output is 0, including arready and awready.
  - Asserting reset mid-transaction abandons the transaction. No rvalid or bvalid is issued afterwards.
- Read latency: AR handshake at edge T; ram_en high in cycle T+1; rvalid high from cycle T+3. Each further beat costs 3 cycles with rready held high.
- Write: AW handshake at edge T; wready high from cycle T+1. Each beat takes one cycle when wvalid is high. bvalid rises in the cycle after the last W handshake.
- Handshake rules:
  - rvalid and bvalid, once high, stay high with stable payload until the handshake.
  - No new AR or AW is accepted until the current transaction completes through R last or B.
- Simultaneous AR and AW in IDLE: exactly one is accepted per the alternation rule; the other waits in IDLE.

## Test plan
- Single read:
  - Stimulus: SRAM word 0x10 = 0xDEADBEEF; AR araddr=0x40, arlen=0, arid=3.
  - Required: one ram_en read at ram_addr=0x10; rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00, rvalid 3 cycles after AR.
- Byte write:
  - Stimulus: AW awaddr=0x41, awsize=0; W wstrb=0010, wdata=0x0000AB00.
  - Required: ram_wen=0010 at ram_addr=0x10; bvalid with bid echoed; a readback returns 0xDEADABEF.
- INCR read burst:
  - Stimulus: arlen=3, araddr=0x100, rready low for 2 cycles on beat 1.
  - Required: 4 beats from words 0x40–0x43; rdata held stable while stalled; rlast only on beat 4.
- FIXED write burst:
  - Stimulus: awburst=00, awlen=2, data 1, 2, 3, with wlast wrongly asserted on beat 2.
  - Required: 3 writes, all to the same word; the final word is 3; one B response after beat 3.
- Simultaneous requests:
  - Stimulus: arvalid and awvalid raised together, twice, starting from reset.
  - Required: write accepted first, then the read; on the next simultaneous pair, read is accepted first.
- Reset mid-burst:
  - Stimulus: drop rst during beat 2 of a 4-beat read.
  - Required: all outputs 0 immediately; after rst rises, a new AR is accepted normally and no stale R beat appears.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI3 slave serving single beats and FIXED/INCR bursts (up to 16 beats) from a
// single-port synchronous SRAM with 1-cycle read latency, one transaction at a time.
module axi_sram_responder #(
  parameter int RAM_AW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_CAP  = 3'd2,
    RD_RESP = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        last_w_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  beats_q;
  logic [31:0] rdata_q;

  logic        grant_w, ar_take, aw_take, w_beat, r_beat, advance;
  logic [31:0] next_addr;

  // Every channel transfers on a cycle where valid and ready are both high at the
  // rising edge; valid never waits for ready, and R/B payloads hold until taken.
  assign grant_w   = awvalid && (!arvalid || !last_w_q);
  assign ar_take   = rst && (state_q == IDLE) && arvalid && !grant_w;
  assign aw_take   = rst && (state_q == IDLE) && awvalid && (grant_w || !arvalid);
  assign w_beat    = (state_q == WR_DATA) && wvalid;
  assign r_beat    = (state_q == RD_RESP) && rready;
  assign advance   = (w_beat || r_beat) && (beats_q != 4'd0);
  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_take)      state_d = RD_REQ;
        else if (aw_take) state_d = WR_DATA;
      end
      RD_REQ:  state_d = RD_CAP;
      RD_CAP:  state_d = RD_RESP;
      RD_RESP: if (rready) state_d = (beats_q == 4'd0) ? IDLE : RD_REQ;
      WR_DATA: if (wvalid && beats_q == 4'd0) state_d = WR_RESP;
      WR_RESP: if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_w_q <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beats_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ar_take || aw_take) begin
        last_w_q <= aw_take;
        id_q     <= aw_take ? awid    : arid;
        addr_q   <= aw_take ? awaddr  : araddr;
        size_q   <= aw_take ? awsize  : arsize;
        burst_q  <= aw_take ? awburst : arburst;
        beats_q  <= aw_take ? awlen   : arlen;
      end else if (advance) begin
        beats_q <= beats_q - 4'd1;
        addr_q  <= next_addr;
      end
      if (state_q == RD_CAP) rdata_q <= ram_rdata;
    end
  end

  assign arready   = ar_take;
  assign awready   = aw_take;
  assign rvalid    = (state_q == RD_RESP);
  assign rid       = rvalid ? id_q : 4'd0;
  assign rdata     = rdata_q;
  assign rresp     = 2'b00;
  assign rlast     = rvalid && (beats_q == 4'd0);
  assign wready    = (state_q == WR_DATA);
  assign bvalid    = (state_q == WR_RESP);
  assign bid       = bvalid ? id_q : 4'd0;
  assign bresp     = 2'b00;
  assign ram_en    = (state_q == RD_REQ) || w_beat;
  assign ram_wen   = w_beat ? wstrb : 4'b0000;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_wdata = w_beat ? wdata : 32'd0;
  assign dbg_state = state_q;

  // Protection/cache attributes, wid and wlast carry no meaning for plain RAM.
  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast};

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a behavioural 1-cycle-latency SRAM.
module tb_axi_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [3:0]  arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid, ram_en;
  logic [3:0]  rid, bid, ram_wen;
  logic [31:0] rdata, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [1:0]  rresp, bresp;
  logic [15:0] ram_addr;
  logic [2:0]  dbg_state;

  logic [31:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  axi_sram_responder #(.RAM_AW(16)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'h0), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'h0), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // Clock / SRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end 1 ns after a rising edge.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, output bit ok);
    int n = 0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin @(posedge clk); #1; n++; end
    ok = arready;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, output bit ok);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    #1;
    while (!awready && n < 50) begin @(posedge clk); #1; n++; end
    ok = awready;
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok,
                        output logic en_o, output logic [3:0] wen_o, output logic [15:0] addr_o,
                        output logic [31:0] wd_o);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    #1;
    while (!wready && n < 50) begin @(posedge clk); #1; n++; end
    ok = wready; en_o = ram_en; wen_o = ram_wen; addr_o = ram_addr; wd_o = ram_wdata;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic recv_r(output logic [31:0] d, output logic [3:0] id, output logic [1:0] rs,
                        output logic l, output bit ok);
    int n = 0;
    rready = 1'b1;
    #1;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    ok = rvalid; d = rdata; id = rid; rs = rresp; l = rlast;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic recv_b(output logic [3:0] id, output logic [1:0] rs, output bit ok);
    int n = 0;
    bready = 1'b1;
    #1;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    ok = bvalid; id = bid; rs = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    @(posedge clk); #1;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checks++;
    if ({arready, awready, wready, rvalid, bvalid, ram_en, ram_wen, dbg_state} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {arready, awready, wready, rvalid, bvalid, ram_en, ram_wen, dbg_state});
    end
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_idle: arready=%b state=%0d expected 0/0", arready, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    bit ok; logic [31:0] d; logic [3:0] id; logic [1:0] rs; logic l;
    mem[16'h10] = 32'hDEADBEEF;
    send_ar(4'd3, 32'h40, 4'd0, 3'd2, 2'b01, ok);
    checks++;
    if (!ok || ram_en !== 1'b1 || ram_wen !== 4'd0 || ram_addr !== 16'h10) begin
      errors++;
      $display("FAIL single_read_strobe: ok=%b en=%b wen=%h addr=%h expected 1/1/0/0010", ok, ram_en, ram_wen, ram_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b0 || ram_en !== 1'b0) begin
      errors++; $display("FAIL single_read_early: rvalid=%b en=%b expected 0/0", rvalid, ram_en);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rid !== 4'd3 || rlast !== 1'b1 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL single_read_beat: rvalid=%b rdata=%h rid=%0d rlast=%b rresp=%b expected 1/deadbeef/3/1/00",
               rvalid, rdata, rid, rlast, rresp);
    end
    recv_r(d, id, rs, l, ok);
    #1;
    checks++;
    if (rvalid !== 1'b0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL single_read_done: rvalid=%b state=%0d expected 0/0", rvalid, dbg_state);
    end
  endtask

  task automatic test_byte_write();
    bit ok; logic en; logic [3:0] wen, id; logic [15:0] a; logic [31:0] wd, d; logic [1:0] rs; logic l;
    send_aw(4'd5, 32'h41, 4'd0, 3'd0, 2'b01, ok);
    send_w(32'h0000AB00, 4'b0010, 1'b1, ok, en, wen, a, wd);
    checks++;
    if (!ok || en !== 1'b1 || wen !== 4'b0010 || a !== 16'h10 || wd !== 32'h0000AB00) begin
      errors++;
      $display("FAIL byte_write_strobe: ok=%b en=%b wen=%b addr=%h wdata=%h expected 1/1/0010/0010/0000ab00", ok, en, wen, a, wd);
    end
    checks++;
    if (bvalid !== 1'b1 || bid !== 4'd5) begin
      errors++; $display("FAIL byte_write_bvalid: bvalid=%b bid=%0d expected 1/5", bvalid, bid);
    end
    recv_b(id, rs, ok);
    checks++;
    if (!ok || id !== 4'd5 || rs !== 2'b00) begin
      errors++; $display("FAIL byte_write_b: ok=%b bid=%0d bresp=%b expected 1/5/00", ok, id, rs);
    end
    send_ar(4'd2, 32'h40, 4'd0, 3'd2, 2'b01, ok);
    recv_r(d, id, rs, l, ok);
    checks++;
    if (!ok || d !== 32'hDEADABEF || id !== 4'd2) begin
      errors++; $display("FAIL byte_write_readback: ok=%b rdata=%h rid=%0d expected 1/deadabef/2", ok, d, id);
    end
  endtask

  task automatic test_incr_burst();
    bit ok; logic [31:0] d; logic [3:0] id; logic [1:0] rs; logic l; int n = 0;
    for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'hA0A00000 + i;
    send_ar(4'd7, 32'h100, 4'd3, 3'd2, 2'b01, ok);
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA0A00000 || rlast !== 1'b0) begin
      errors++; $display("FAIL incr_beat1: rvalid=%b rdata=%h rlast=%b expected 1/a0a00000/0", rvalid, rdata, rlast);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA0A00000 || rlast !== 1'b0 || rid !== 4'd7) begin
      errors++;
      $display("FAIL incr_stall_hold: rvalid=%b rdata=%h rlast=%b rid=%0d expected 1/a0a00000/0/7", rvalid, rdata, rlast, rid);
    end
    recv_r(d, id, rs, l, ok);
    for (int i = 1; i < 4; i++) begin
      recv_r(d, id, rs, l, ok);
      checks++;
      if (!ok || d !== 32'hA0A00000 + i || l !== (i == 3) || id !== 4'd7) begin
        errors++;
        $display("FAIL incr_beat%0d: ok=%b rdata=%h rlast=%b rid=%0d expected 1/%h/%b/7", i + 1, ok, d, l, id,
                 32'hA0A00000 + i, (i == 3));
      end
    end
    checks++;
    if (dbg_state !== 3'd0 || rvalid !== 1'b0) begin
      errors++; $display("FAIL incr_end: state=%0d rvalid=%b expected 0/0", dbg_state, rvalid);
    end
  endtask

  task automatic test_fixed_write();
    bit ok; logic en; logic [3:0] wen, id; logic [15:0] a; logic [31:0] wd; logic [1:0] rs;
    send_aw(4'd9, 32'h80, 4'd2, 3'd2, 2'b00, ok);
    for (int i = 1; i <= 3; i++) begin
      send_w(32'(i), 4'hF, (i == 2), ok, en, wen, a, wd);
      checks++;
      if (!ok || en !== 1'b1 || wen !== 4'hF || a !== 16'h20 || wd !== 32'(i)) begin
        errors++;
        $display("FAIL fixed_beat%0d: ok=%b en=%b wen=%h addr=%h wdata=%h expected 1/1/f/0020/%h", i, ok, en, wen, a, wd, i);
      end
      checks++;
      if (bvalid !== (i == 3) || wready !== (i != 3)) begin
        errors++;
        $display("FAIL fixed_after%0d: bvalid=%b wready=%b expected %b/%b", i, bvalid, wready, (i == 3), (i != 3));
      end
    end
    checks++;
    if (mem[16'h20] !== 32'd3) begin
      errors++; $display("FAIL fixed_final_word: got %h expected 00000003", mem[16'h20]);
    end
    recv_b(id, rs, ok);
    #1;
    checks++;
    if (!ok || id !== 4'd9 || rs !== 2'b00 || bvalid !== 1'b0) begin
      errors++; $display("FAIL fixed_b: ok=%b bid=%0d bresp=%b bvalid_after=%b expected 1/9/00/0", ok, id, rs, bvalid);
    end
  endtask

  task automatic test_simultaneous();
    bit ok; logic en; logic [3:0] wen, id; logic [15:0] a; logic [31:0] wd, d; logic [1:0] rs; logic l; int n = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    arid = 4'd1; araddr = 32'h40; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    awid = 4'd2; awaddr = 32'hC0; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      errors++; $display("FAIL sim_first_pair: awready=%b arready=%b expected 1/0", awready, arready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    send_w(32'h12345678, 4'hF, 1'b1, ok, en, wen, a, wd);
    awid = 4'd4; awaddr = 32'hC4; awvalid = 1'b1;
    recv_b(id, rs, ok);
    #1;
    checks++;
    if (!ok || id !== 4'd2 || arready !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL sim_second_pair: bok=%b bid=%0d arready=%b awready=%b expected 1/2/1/0", ok, id, arready, awready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    checks++;
    if (dbg_state !== 3'd1 || awready !== 1'b0) begin
      errors++; $display("FAIL sim_no_aw_during_read: state=%0d awready=%b expected 1/0", dbg_state, awready);
    end
    recv_r(d, id, rs, l, ok);
    checks++;
    if (!ok || d !== 32'hDEADABEF || id !== 4'd1) begin
      errors++; $display("FAIL sim_read: ok=%b rdata=%h rid=%0d expected 1/deadabef/1", ok, d, id);
    end
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    ok = awready;
    @(posedge clk); #1;
    awvalid = 1'b0;
    send_w(32'h9ABCDEF0, 4'hF, 1'b1, ok, en, wen, a, wd);
    recv_b(id, rs, ok);
    checks++;
    if (!ok || id !== 4'd4 || mem[16'h30] !== 32'h12345678 || mem[16'h31] !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL sim_writes: ok=%b bid=%0d w30=%h w31=%h expected 1/4/12345678/9abcdef0", ok, id, mem[16'h30], mem[16'h31]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok; logic [31:0] d; logic [3:0] id; logic [1:0] rs; logic l; int n = 0; int stale = 0;
    send_ar(4'd6, 32'h100, 4'd3, 3'd2, 2'b01, ok);
    recv_r(d, id, rs, l, ok);
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA0A00001) begin
      errors++; $display("FAIL midrst_beat2: rvalid=%b rdata=%h expected 1/a0a00001", rvalid, rdata);
    end
    rst = 1'b0; arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    #1;
    checks++;
    if ({arready, awready, wready, rvalid, rlast, bvalid, ram_en} !== 7'd0 || rid !== 4'd0 || bid !== 4'd0 ||
        rdata !== 32'd0 || ram_wen !== 4'd0 || ram_addr !== 16'd0 || ram_wdata !== 32'd0) begin
      errors++;
      $display("FAIL midrst_outputs: ctl=%b rid=%0d bid=%0d rdata=%h wen=%h addr=%h wdata=%h expected all 0",
               {arready, awready, wready, rvalid, rlast, bvalid, ram_en}, rid, bid, rdata, ram_wen, ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wstrb = 4'h0; rready = 1'b1;
    repeat (6) begin
      #1; if (rvalid) stale++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    checks++;
    if (stale !== 0) begin
      errors++; $display("FAIL midrst_stale_r: got %0d beats expected 0", stale);
    end
    send_ar(4'd8, 32'h104, 4'd0, 3'd2, 2'b01, ok);
    recv_r(d, id, rs, l, ok);
    checks++;
    if (!ok || d !== 32'hA0A00001 || id !== 4'd8 || l !== 1'b1) begin
      errors++; $display("FAIL midrst_new_read: ok=%b rdata=%h rid=%0d rlast=%b expected 1/a0a00001/8/1", ok, d, id, l);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_incr_burst();
    test_fixed_write();
    test_simultaneous();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
